// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter.
// - state_e      : arbiter FSM encoding (IDLE, grant to 0, grant to 1)
// - GNT_*        : one-hot grant constants driven on gnt
// - state_to_gnt : maps an FSM state onto its one-hot grant
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_0    = 2'b01;
    localparam logic [1:0] GNT_1    = 2'b10;

    function automatic logic [1:0] state_to_gnt(input state_e st);
        logic [1:0] g;
        g = GNT_NONE;
        case (st)
            ST_G0:   g = GNT_0;
            ST_G1:   g = GNT_1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter for the arbiter.
// Counts cycles the current grant has been retained and stops at MAX_HOLD-1.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   clr_i : clear to zero (grant entry); has priority over en_i
//   en_i  : advance by one unless already at the cap
//   tc_o  : terminal count, high while the count equals MAX_HOLD-1
module mux_arb_hold_cnt #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CAP = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With MAX_HOLD=1 the cap is zero, so tc is permanently high and the
    // holder yields every cycle the other side is requesting.
    assign tc_o = (cnt_q == CAP);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that shares one registered 2:1 mux between two
// requesters. Grants are demand driven; under contention the holder is
// forced to yield after MAX_HOLD consecutive cycles.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   req       : request lines, req[i] for requester i
//   in0, in1  : data from requester 0 / 1
//   gnt       : registered one-hot grant, 00 when idle
//   sel       : registered mux select (0 = in0, 1 = in1), held while idle
//   out       : registered mux output, held while idle
//   out_valid : high while a grant is active
module mux2_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             hold_tc;
    logic             grant_entry;
    logic             grant_keep;

    logic [1:0]       gnt_q;
    logic             sel_q;
    logic [WIDTH-1:0] out_q;
    logic             vld_q;

    mux_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (grant_entry),
        .en_i  (grant_keep),
        .tc_o  (hold_tc)
    );

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (req == 2'b11) begin
                    // Tie: favour whoever did not hold the grant last.
                    state_d = last_q ? ST_G0 : ST_G1;
                end else if (req[0]) begin
                    state_d = ST_G0;
                end else if (req[1]) begin
                    state_d = ST_G1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_G0: begin
                if (!req[0]) begin
                    state_d = req[1] ? ST_G1 : ST_IDLE;
                end else if (req[1] && hold_tc) begin
                    state_d = ST_G1;
                end else begin
                    state_d = ST_G0;
                end
            end
            ST_G1: begin
                if (!req[1]) begin
                    state_d = req[0] ? ST_G0 : ST_IDLE;
                end else if (req[0] && hold_tc) begin
                    state_d = ST_G0;
                end else begin
                    state_d = ST_G1;
                end
            end
            default: state_d = ST_IDLE; // unused code recovers to IDLE
        endcase
    end

    // A grant entry is any move into G0/G1 from a different state, which
    // includes a direct G0<->G1 handover.
    assign grant_entry = (state_d != ST_IDLE) && (state_d != state_q);
    assign grant_keep  = (state_d != ST_IDLE) && (state_d == state_q);

    always_comb begin
        last_d = last_q;
        if (grant_entry) begin
            last_d = (state_d == ST_G1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Output registers, all driven from the next state so the grant and the
    // selected data appear together one edge after the request is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= GNT_NONE;
            sel_q <= 1'b0;
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            gnt_q <= state_to_gnt(state_d);
            vld_q <= (state_d != ST_IDLE);
            if (state_d != ST_IDLE) begin
                sel_q <= (state_d == ST_G1);
                out_q <= (state_d == ST_G1) ? in1 : in0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [3:0] in0;
    logic [3:0] in1;

    logic [1:0] gnt_a;
    logic       sel_a;
    logic [3:0] out_a;
    logic       vld_a;

    logic [1:0] gnt_b;
    logic       sel_b;
    logic [3:0] out_b;
    logic       vld_b;

    int total;
    int bad;

    // Main instance: WIDTH=4, MAX_HOLD=4
    mux2_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .gnt       (gnt_a),
        .sel       (sel_a),
        .out       (out_a),
        .out_valid (vld_a)
    );

    // Second instance with MAX_HOLD=1, same stimulus
    mux2_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .gnt       (gnt_b),
        .sel       (sel_b),
        .out       (out_b),
        .out_valid (vld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b11;
        in0 = 4'hA;
        in1 = 4'h5;
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if (gnt_a !== 2'b00 || out_a !== 4'h0 || vld_a !== 1'b0 || sel_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b sel=%b out=%h vld=%b want gnt=00 sel=0 out=0 vld=0",
                     gnt_a, sel_a, out_a, vld_a);
        end
        step();
        total++;
        if (gnt_a !== 2'b01 || sel_a !== 1'b0 || out_a !== 4'hA || vld_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_tie: gnt=%b sel=%b out=%h vld=%b want gnt=01 sel=0 out=a vld=1",
                     gnt_a, sel_a, out_a, vld_a);
        end
        total++;
        if (gnt_b !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_tie_mh1: gnt=%b want 01", gnt_b);
        end
    endtask

    task automatic test_single();
        logic [1:0] exp_g;
        do_reset();
        req = 2'b10;
        for (int i = 1; i <= 3; i++) begin
            in1 = 4'(i);
            in0 = 4'hF;
            step();
            total++;
            if (gnt_a !== 2'b10 || sel_a !== 1'b1 || out_a !== 4'(i) || vld_a !== 1'b1) begin
                bad++;
                $display("FAIL single_req cyc%0d: gnt=%b sel=%b out=%h vld=%b want gnt=10 sel=1 out=%h vld=1",
                         i, gnt_a, sel_a, out_a, vld_a, 4'(i));
            end
        end
        req = 2'b00;
        in1 = 4'h9;
        step();
        exp_g = 2'b00;
        total++;
        if (gnt_a !== exp_g || vld_a !== 1'b0 || out_a !== 4'h3 || sel_a !== 1'b1) begin
            bad++;
            $display("FAIL single_drop: gnt=%b sel=%b out=%h vld=%b want gnt=00 sel=1 out=3 vld=0",
                     gnt_a, sel_a, out_a, vld_a);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        do_reset();
        req = 2'b11;
        in0 = 4'h1;
        in1 = 4'h2;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_a = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            exp_b = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (gnt_a !== exp_a || vld_a !== 1'b1) begin
                bad++;
                $display("FAIL fair_mh4 cyc%0d: gnt=%b vld=%b want gnt=%b vld=1", i, gnt_a, vld_a, exp_a);
            end
            total++;
            if (gnt_b !== exp_b || out_b !== ((exp_b == 2'b10) ? 4'h2 : 4'h1)) begin
                bad++;
                $display("FAIL fair_mh1 cyc%0d: gnt=%b out=%h want gnt=%b", i, gnt_b, out_b, exp_b);
            end
        end
    endtask

    task automatic test_release_handover();
        do_reset();
        req = 2'b11;
        in0 = 4'h3;
        in1 = 4'h7;
        step();
        step();
        total++;
        if (gnt_a !== 2'b01) begin
            bad++;
            $display("FAIL handover_pre: gnt=%b want 01", gnt_a);
        end
        req = 2'b10;
        step();
        total++;
        if (gnt_a !== 2'b10 || sel_a !== 1'b1 || out_a !== 4'h7 || vld_a !== 1'b1) begin
            bad++;
            $display("FAIL handover: gnt=%b sel=%b out=%h vld=%b want gnt=10 sel=1 out=7 vld=1",
                     gnt_a, sel_a, out_a, vld_a);
        end
        // Cleared counter: G1 keeps the grant for 3 more contended edges.
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (gnt_a !== ((i < 3) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL handover_hold cyc%0d: gnt=%b want %b", i, gnt_a, (i < 3) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 2'b10;
        in1 = 4'h5;
        in0 = 4'hC;
        step();
        total++;
        if (gnt_a !== 2'b10 || out_a !== 4'h5) begin
            bad++;
            $display("FAIL async_pre: gnt=%b out=%h want gnt=10 out=5", gnt_a, out_a);
        end
        rst = 1'b1;
        #2;
        total++;
        if (gnt_a !== 2'b00 || sel_a !== 1'b0 || out_a !== 4'h0 || vld_a !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: gnt=%b sel=%b out=%h vld=%b want gnt=00 sel=0 out=0 vld=0",
                     gnt_a, sel_a, out_a, vld_a);
        end
        rst = 1'b0;
        req = 2'b11;
        step();
        total++;
        if (gnt_a !== 2'b01 || out_a !== 4'hC) begin
            bad++;
            $display("FAIL async_post_tie: gnt=%b out=%h want gnt=01 out=c", gnt_a, out_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        req = 2'b01;
        in0 = 4'h6;
        in1 = 4'hB;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (gnt_a !== 2'b01 || vld_a !== 1'b1) begin
                bad++;
                $display("FAIL sat_hold cyc%0d: gnt=%b vld=%b want gnt=01 vld=1", i, gnt_a, vld_a);
            end
        end
        req = 2'b11;
        step();
        total++;
        if (gnt_a !== 2'b10 || out_a !== 4'hB || sel_a !== 1'b1) begin
            bad++;
            $display("FAIL sat_handover: gnt=%b sel=%b out=%h want gnt=10 sel=1 out=b", gnt_a, sel_a, out_a);
        end
    endtask

    task automatic test_both_drop();
        do_reset();
        req = 2'b01;
        in0 = 4'h4;
        step();
        req = 2'b00;
        step();
        total++;
        if (gnt_a !== 2'b00 || vld_a !== 1'b0 || out_a !== 4'h4 || sel_a !== 1'b0) begin
            bad++;
            $display("FAIL both_drop: gnt=%b sel=%b out=%h vld=%b want gnt=00 sel=0 out=4 vld=0",
                     gnt_a, sel_a, out_a, vld_a);
        end
        // Last holder was 0, so the next tie from idle goes to 1.
        req = 2'b11;
        step();
        total++;
        if (gnt_a !== 2'b10) begin
            bad++;
            $display("FAIL rr_tie_after_idle: gnt=%b want 10", gnt_a);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 2'b00;
        in0   = 4'h0;
        in1   = 4'h0;
        test_reset();
        test_single();
        test_fairness();
        test_release_handover();
        test_async_reset();
        test_saturation();
        test_both_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 multiplexer between two requesters.
- Accepts per-requester request lines and data, and drives the mux select.
- Produces a registered, one-hot grant and a registered, validated output word.
- Sits in front of the existing 2:1 mux datapath; replaces free-running select toggling with demand-driven, fair selection.

Parameters:
- WIDTH, 1: data width of each mux input and of the output.
- MAX_HOLD, 4: maximum consecutive cycles one requester keeps the grant while the other is requesting. Legal range is 1..255.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  2  request lines; req[i] high means requester i wants the mux.
- in0  input  WIDTH  data from requester 0.
- in1  input  WIDTH  data from requester 1.
- gnt  output  2  registered one-hot grant; 00 when idle.
- sel  output  1  registered mux select; 0 = in0, 1 = in1.
- out  output  WIDTH  registered mux output.
- out_valid  output  1  high while a grant is active.

Behaviour:
- Reset (async assert, any time; release is sampled synchronously at clk):
  - state=IDLE, gnt=00, sel=0, out=0, out_valid=0, hold_cnt=0.
  - last=1, so requester 0 wins the first tie.
- States: IDLE, G0, G1. On each rising edge, next state is computed from req and current state.
- IDLE:
  - req=01 -> G0; req=10 -> G1.
  - req=11 -> grant to ~last.
  - req=00 -> stay IDLE.
- G0 (G1 is symmetric):
  - req[0]=0 -> G1 if req[1], else IDLE. Direct G0->G1 handover has no idle bubble.
  - req[0]=1, req[1]=1, hold_cnt==MAX_HOLD-1 -> forced handover to G1.
  - Otherwise stay in G0.
- hold_cnt:
  - Cleared on every grant entry, including IDLE->Gx and Gx->Gy.
  - Increments each cycle the grant is retained.
  - Saturates at MAX_HOLD-1. With no competitor it sits at the cap; no handover occurs until the other requester asserts.
  - Width is ceil(log2(MAX_HOLD)), minimum 1.
- last: set to the granted index on each grant entry.
- Registered outputs, all updated from the next state at the same edge:
  - gnt = one-hot of the next state.
  - sel = 1 for G1, 0 for G0; holds its previous value in IDLE.
  - out = next state G1 ? in1 : in0, sampled at that edge.
  - In IDLE, out holds its previous value.
  - out_valid = (next state != IDLE).
- Latency: req sampled high at edge n -> gnt, sel, out, out_valid reflect it after edge n. That is one cycle from request assertion to visible grant; zero additional cycles for data.
- While granted, out tracks the granted input every cycle, one register stage behind.
- A grant drops in the cycle after its req is sampled low. A requester deasserting never sees its grant extended.
- MAX_HOLD=1 under continuous contention: grant alternates every cycle (G0,G1,G0,...).
- Simultaneous events:
  - Holder deasserts while the other asserts in the same cycle: handover, not IDLE.
  - Both deassert: IDLE.
- Reset mid-grant: outputs clear immediately, without waiting for clk. First post-reset tie goes to requester 0.
- No illegal states: the encoding has 3 used codes; an unused code recovers to IDLE on the next edge.

Decomposition:
- Package mux_arb_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_G0=2'd1, ST_G1=2'd2.
  - Grant one-hot constants GNT_NONE, GNT_0, GNT_1.
- One sub-module, mux_arb_hold_cnt:
  - Saturating hold counter with clear, enable and terminal-count outputs.
  - Parameterised by MAX_HOLD, same clk/rst.
- The arbiter FSM, output registers and the mux itself stay in mux2_arbiter.

Test Plan (WIDTH=4, MAX_HOLD=4 unless stated):
- Reset with req=11, in0=4'hA, in1=4'h5, then release rst -> after release: gnt=00, out=0, out_valid=0. After first edge: gnt=01, sel=0, out=4'hA, out_valid=1.
- Single requester: req=10, in1 counts 1,2,3 per cycle -> gnt=10 one edge after req; out=1,2,3 one cycle behind in1. Drop req -> gnt=00 and out_valid=0 next edge; out holds 3.
- Contention fairness: req=11 held 12 cycles from IDLE -> gnt sequence is 01×4, 10×4, 01×4, with no 00 cycles. Repeat with MAX_HOLD=1 -> alternating 01,10 each cycle.
- Release handover: G0 active with req=11; set req=10 at hold_cnt=1 -> next edge gnt=10, sel=1, out=in1, out_valid stays 1; hold_cnt cleared.
- Async reset mid-grant: in G1 with out=4'h5, pulse rst between edges -> gnt=00, sel=0, out=0, out_valid=0 before the next clk edge. Next tie with req=11 grants 01.
- Saturation without competitor: req=01 for 10 cycles -> gnt stays 01 throughout. Then req=11 -> handover to 10 on the following edge, since hold_cnt is at the cap.
